// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// Outputs come straight from the main register; ready_o is a pure function of registered state.
module pipe_skid_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter int                 DATA_W    = 32,
    parameter int                 CTRL_W    = 8,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [CTRL_W-1:0]  ctrl_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic [1:0]         count_o
);
    logic               m_valid, s_valid;
    logic [INSTR_W-1:0] m_instr, s_instr, n_instr;
    logic [PC_W-1:0]    m_pc, s_pc, n_pc;
    logic [DATA_W-1:0]  m_data, s_data, n_data;
    logic [CTRL_W-1:0]  m_ctrl, s_ctrl, n_ctrl;
    logic               accept, fire, m_load;

    assign ready_o = ~s_valid;
    assign accept  = valid_i & ready_o;
    assign fire    = m_valid & ready_i;
    assign m_load  = ~m_valid | fire;

    // The skid entry is older than any incoming beat, so it always refills M first.
    always_comb begin
        n_instr = s_valid ? s_instr : accept ? instr_i : NOP_INSTR;
        n_pc    = s_valid ? s_pc    : accept ? pc_i    : '0;
        n_data  = s_valid ? s_data  : accept ? data_i  : '0;
        n_ctrl  = s_valid ? s_ctrl  : accept ? ctrl_i  : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni || flush_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_instr <= NOP_INSTR;
            m_pc    <= '0;
            m_data  <= '0;
            m_ctrl  <= '0;
        end else if (m_load) begin
            m_valid <= s_valid | accept;
            s_valid <= 1'b0;
            m_instr <= n_instr;
            m_pc    <= n_pc;
            m_data  <= n_data;
            m_ctrl  <= n_ctrl;
        end else if (accept) begin
            s_valid <= 1'b1;
        end
    end

    // Skid payload is only observable through s_valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (accept && !m_load) begin
            s_instr <= instr_i;
            s_pc    <= pc_i;
            s_data  <= data_i;
            s_ctrl  <= ctrl_i;
        end
    end

    assign valid_o = m_valid;
    assign instr_o = m_instr;
    assign pc_o    = m_pc;
    assign data_o  = m_data;
    assign ctrl_o  = m_ctrl;
    assign count_o = {1'b0, m_valid} + {1'b0, s_valid};
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus randomized run against a two-deep FIFO model.
module tb_pipe_skid_reg;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, flush, vin, rdy_out, vout, rdy_in;
    logic [31:0] instr_in, pc_in, data_in, instr_out, pc_out, data_out;
    logic [7:0]  ctrl_in, ctrl_out;
    logic [1:0]  count;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] data;
        logic [7:0]  ctrl;
    } beat_t;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        valid;
        logic        ready;
        logic [31:0] pc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [1:0]  exp_count;
        logic        exp_ready;
    } vec_t;

    pipe_skid_reg dut (
        .clk_i(clk), .reset_ni(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(rdy_out),
        .instr_i(instr_in), .pc_i(pc_in), .data_i(data_in), .ctrl_i(ctrl_in),
        .valid_o(vout), .ready_i(rdy_in), .instr_o(instr_out), .pc_o(pc_out),
        .data_o(data_out), .ctrl_o(ctrl_out), .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input logic [31:0] pc);
        mk = '{instr: {16'hA5A5, pc[15:0]}, pc: pc, data: ~pc, ctrl: pc[7:0] ^ 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input beat_t b);
        instr_in = b.instr;
        pc_in    = b.pc;
        data_in  = b.data;
        ctrl_in  = b.ctrl;
    endtask

    // Compare every output against a model state: queue head (if any) and depth.
    task automatic chk_state(input string tag, input logic v, input beat_t b, input int n);
        chk({tag, " valid_o"}, 64'(vout), 64'(v));
        chk({tag, " instr_o"}, 64'(instr_out), 64'(v ? b.instr : NOP));
        chk({tag, " pc_o"}, 64'(pc_out), 64'(v ? b.pc : 32'h0));
        chk({tag, " data_o"}, 64'(data_out), 64'(v ? b.data : 32'h0));
        chk({tag, " ctrl_o"}, 64'(ctrl_out), 64'(v ? b.ctrl : 8'h0));
        chk({tag, " count_o"}, 64'(count), 64'(n));
        chk({tag, " ready_o"}, 64'(rdy_out), 64'(n < 2));
    endtask

    vec_t  vecs[$];
    beat_t q[$];
    beat_t hold_b;
    logic  hold_v;

    initial begin
        // rst flush valid ready pc | exp valid pc count ready
        vecs = '{
            '{1,0,1,1, 0, 1, 0,1,1}, '{1,0,1,1, 4, 1, 4,1,1}, '{1,0,1,1, 8, 1, 8,1,1},
            '{1,0,1,1,12, 1,12,1,1}, '{1,0,0,1, 0, 0, 0,0,1},
            '{1,0,1,0, 0, 1, 0,1,1}, '{1,0,1,0, 4, 1, 0,2,0}, '{1,0,1,0, 8, 1, 0,2,0},
            '{1,0,1,1, 8, 1, 4,1,1}, '{1,0,1,1, 8, 1, 8,1,1}, '{1,0,0,1, 0, 0, 0,0,1},
            '{1,0,1,0,16, 1,16,1,1}, '{1,0,1,0,20, 1,16,2,0}, '{1,1,1,0,24, 0, 0,0,1},
            '{1,0,0,1, 0, 0, 0,0,1},
            '{1,0,1,0,28, 1,28,1,1}, '{1,0,1,0,32, 1,28,2,0}, '{0,0,1,0,36, 0, 0,0,1},
            '{1,0,1,1,40, 1,40,1,1}, '{1,0,0,1, 0, 0, 0,0,1}
        };

        rst_n = 1'b0; flush = 1'b0; vin = 1'b1; rdy_in = 1'b0;
        instr_in = 32'hDEADBEEF; pc_in = 32'h100; data_in = 32'h55; ctrl_in = 8'hFF;
        @(posedge clk); #1;
        chk("reset instr_o", 64'(instr_out), 64'(NOP));
        chk("reset valid_o", 64'(vout), 64'd0);
        chk("reset count_o", 64'(count), 64'd0);
        chk("reset ready_o", 64'(rdy_out), 64'd1);
        chk("reset ctrl_o", 64'(ctrl_out), 64'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; flush = vecs[i].flush;
            vin = vecs[i].valid; rdy_in = vecs[i].ready;
            drive(mk(vecs[i].pc));
            @(posedge clk); #1;
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, mk(vecs[i].exp_pc),
                      int'(vecs[i].exp_count));
        end

        // Randomized run: model is a two-entry FIFO whose head is what the outputs show.
        @(negedge clk);
        rst_n = 1'b0; vin = 1'b0; flush = 1'b0;
        @(posedge clk);
        q.delete();
        hold_v = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (!hold_v) begin
                hold_v = ($urandom_range(3) != 0);
                hold_b = '{instr: $urandom, pc: $urandom, data: $urandom, ctrl: 8'($urandom)};
            end
            vin    = hold_v;
            drive(hold_b);
            rdy_in = ($urandom_range(2) != 0);
            flush  = ($urandom_range(96) == 0);
            #1;
            chk_state("rand", q.size() > 0, q.size() > 0 ? q[0] : beat_t'('0), q.size());
            begin
                logic r0;
                r0 = rdy_out;
                rdy_in = ~rdy_in;
                #1;
                chk("ready_o vs ready_i", 64'(rdy_out), 64'(r0));
                rdy_in = ~rdy_in;
                #1;
            end
            @(posedge clk);
            if (flush) begin
                q.delete();
                hold_v = 1'b0;
            end else begin
                logic acc;
                acc = vin && q.size() < 2;
                if (q.size() > 0 && rdy_in) void'(q.pop_front());
                if (acc) begin
                    q.push_back(hold_b);
                    hold_v = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
